// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its lamp monitor.
// Holds the phase encoding, the monitor's error codes, the legal-successor
// function and the lamp-to-phase decode.
package traffic_pkg;

  // Phase encoding, identical to the one the controller uses.
  typedef enum logic [1:0] {
    PhRed    = 2'b00,
    PhGreen  = 2'b01,
    PhYellow = 2'b10
  } phase_e;

  typedef enum logic [2:0] {
    ErrNone       = 3'd0,
    ErrNotOnehot  = 3'd1,
    ErrBadSeq     = 3'd2,
    ErrShortDwell = 3'd3,
    ErrLongDwell  = 3'd4
  } err_code_e;

  // Legal successor of a phase: RED -> GREEN -> YELLOW -> RED.
  function automatic phase_e next_phase(phase_e ph);
    case (ph)
      PhRed:   return PhGreen;
      PhGreen: return PhYellow;
      default: return PhRed;
    endcase
  endfunction

  // Lamp vector is {red, yellow, green}; only meaningful when one-hot.
  function automatic phase_e lamp_to_phase(logic [2:0] lamp);
    if (lamp[2]) begin
      return PhRed;
    end else if (lamp[0]) begin
      return PhGreen;
    end
    return PhYellow;
  endfunction

endpackage

// File: rtl/phase_dwell_counter.sv
// Dwell counter for the current lamp phase, with per-phase limit compares.
//
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   restart_i       load 1 (first cycle of a new phase instance)
//   incr_i          count one more cycle of the same phase (saturates)
//   phase_i         phase whose limits are used for the compares
//   below_min_o     dwell is below the phase's MIN
//   at_max_o        dwell equals the phase's MAX (next increment overruns)
module phase_dwell_counter
  import traffic_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned RED_MIN = 1,
  parameter int unsigned RED_MAX = 1,
  parameter int unsigned GRN_MIN = 1,
  parameter int unsigned GRN_MAX = 1,
  parameter int unsigned YEL_MIN = 1,
  parameter int unsigned YEL_MAX = 1
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   restart_i,
  input  logic   incr_i,
  input  phase_e phase_i,
  output logic   below_min_o,
  output logic   at_max_o
);

  localparam logic [DWELL_W-1:0] DwellSat = '1;

  logic [DWELL_W-1:0] dwell_d, dwell_q;
  logic [DWELL_W-1:0] min_lim, max_lim;

  always_comb begin
    dwell_d = dwell_q;
    if (restart_i) begin
      dwell_d = DWELL_W'(1);
    end else if (incr_i && (dwell_q != DwellSat)) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  always_comb begin
    case (phase_i)
      PhRed: begin
        min_lim = DWELL_W'(RED_MIN);
        max_lim = DWELL_W'(RED_MAX);
      end
      PhGreen: begin
        min_lim = DWELL_W'(GRN_MIN);
        max_lim = DWELL_W'(GRN_MAX);
      end
      default: begin
        min_lim = DWELL_W'(YEL_MIN);
        max_lim = DWELL_W'(YEL_MAX);
      end
    endcase
  end

  assign below_min_o = dwell_q < min_lim;
  // MAX < all-ones, so dwell passes MAX exactly once per phase instance.
  assign at_max_o    = dwell_q == max_lim;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Passive monitor on the traffic-light lamp outputs. Registers the lamps,
// rebuilds the phase, flags non-one-hot lamps and illegal phase order, counts
// completed light cycles (YELLOW -> RED) and reports errors through a pulse,
// a sticky flag and a first-error code.
//
// Build option: define TRAFFIC_LAMP_MON_DWELL_CHECK_EN to add the per-phase
// dwell counter and the SHORT_DWELL / LONG_DWELL checks.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   red/yellow/green lamp inputs
//   clr_err          synchronous clear of err_sticky / err_code
//   phase            tracked phase (RED=00, GREEN=01, YELLOW=10)
//   phase_valid      monitor is tracking
//   cycle_count      completed light cycles, wrapping
//   err_pulse        one cycle per detected error
//   err_sticky       any error since last clear
//   err_code         first error since last clear
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned RED_MIN = 1,
  parameter int unsigned RED_MAX = 1,
  parameter int unsigned GRN_MIN = 1,
  parameter int unsigned GRN_MAX = 1,
  parameter int unsigned YEL_MIN = 1,
  parameter int unsigned YEL_MAX = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CYC_W-1:0] cycle_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [2:0]       err_code
);

  typedef enum logic [0:0] {StSync, StTrack} state_e;

  state_e             state_d, state_q;
  logic [2:0]         lamp_q;
  phase_e             phase_d, phase_q;
  logic [CYC_W-1:0]   cycle_count_d, cycle_count_q;
  logic               short_ok_d, short_ok_q;
  logic               err_pulse_d, err_pulse_q;
  logic               err_sticky_d, err_sticky_q;
  err_code_e          err_code_d, err_code_q;

  logic               lamp_onehot;
  phase_e             lamp_phase;
  err_code_e          err_new;
  logic               dwell_restart, dwell_incr;
  logic               dwell_short, dwell_at_max;

  assign lamp_onehot = $onehot(lamp_q);
  assign lamp_phase  = lamp_to_phase(lamp_q);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cycle_count_d = cycle_count_q;
    short_ok_d    = short_ok_q;
    err_new       = ErrNone;
    dwell_restart = 1'b0;
    dwell_incr    = 1'b0;

    unique case (state_q)
      StSync: begin
        if (lamp_onehot) begin
          state_d       = StTrack;
          phase_d       = lamp_phase;
          dwell_restart = 1'b1;
          // Start time of this phase is unknown, so its length is not judged.
          short_ok_d    = 1'b0;
        end
      end
      StTrack: begin
        if (!lamp_onehot) begin
          err_new = ErrNotOnehot;
          state_d = StSync;
        end else if (lamp_phase == phase_q) begin
          dwell_incr = 1'b1;
          if (dwell_at_max) begin
            err_new = ErrLongDwell;
          end
        end else if (lamp_phase == next_phase(phase_q)) begin
          if (short_ok_q && dwell_short) begin
            err_new = ErrShortDwell;
          end
          if (phase_q == PhYellow) begin
            cycle_count_d = cycle_count_q + CYC_W'(1);
          end
          phase_d       = lamp_phase;
          dwell_restart = 1'b1;
          short_ok_d    = 1'b1;
        end else begin
          err_new       = ErrBadSeq;
          phase_d       = lamp_phase;
          dwell_restart = 1'b1;
          short_ok_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // A new error outranks a simultaneous clear.
  always_comb begin
    err_pulse_d  = err_new != ErrNone;
    err_sticky_d = err_sticky_q;
    err_code_d   = err_code_q;
    if (err_new != ErrNone) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q || clr_err) begin
        err_code_d = err_new;
      end
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_code_d   = ErrNone;
    end
  end

`ifdef TRAFFIC_LAMP_MON_DWELL_CHECK_EN
  phase_dwell_counter #(
    .DWELL_W (DWELL_W),
    .RED_MIN (RED_MIN),
    .RED_MAX (RED_MAX),
    .GRN_MIN (GRN_MIN),
    .GRN_MAX (GRN_MAX),
    .YEL_MIN (YEL_MIN),
    .YEL_MAX (YEL_MAX)
  ) u_dwell (
    .clk_i       (clk),
    .reset_i     (reset),
    .restart_i   (dwell_restart),
    .incr_i      (dwell_incr),
    .phase_i     (phase_q),
    .below_min_o (dwell_short),
    .at_max_o    (dwell_at_max)
  );
`else
  assign dwell_short  = 1'b0;
  assign dwell_at_max = 1'b0;
  logic unused_dwell;
  assign unused_dwell = ^{dwell_restart, dwell_incr,
                          (DWELL_W + RED_MIN + RED_MAX + GRN_MIN + GRN_MAX + YEL_MIN
                           + YEL_MAX) != 0};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamp_q        <= '0;
      state_q       <= StSync;
      phase_q       <= PhRed;
      cycle_count_q <= '0;
      short_ok_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_code_q    <= ErrNone;
    end else begin
      lamp_q        <= {red, yellow, green};
      state_q       <= state_d;
      phase_q       <= phase_d;
      cycle_count_q <= cycle_count_d;
      short_ok_q    <= short_ok_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_code_q    <= err_code_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = state_q == StTrack;
  assign cycle_count = cycle_count_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor. Four instances share the lamp inputs:
//   0: default limits, 1: GRN_MAX=3, 2: CYC_W=2, 3: wider MIN/MAX limits.
// A per-instance reference model tracks phase index (RED=0, GREEN=1,
// YELLOW=2), samples seen in the current phase and the error bookkeeping.
module tb_traffic_lamp_monitor;

  localparam int NDut = 4;
`ifdef TRAFFIC_LAMP_MON_DWELL_CHECK_EN
  localparam bit DwellEn = 1'b1;
`else
  localparam bit DwellEn = 1'b0;
`endif

  localparam logic [2:0] LR   = 3'b100;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LG   = 3'b001;
  localparam logic [2:0] LOff = 3'b000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic red = 1'b0, yellow = 1'b0, green = 1'b0, clr_err = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]  ph_o [NDut];
  logic        pv_o [NDut];
  logic        ep_o [NDut];
  logic        es_o [NDut];
  logic [2:0]  ec_o [NDut];
  logic [15:0] cc_o [NDut];
  logic [15:0] cc0, cc1, cc3;
  logic [1:0]  cc2;

  assign cc_o[0] = cc0;
  assign cc_o[1] = cc1;
  assign cc_o[2] = {14'd0, cc2};
  assign cc_o[3] = cc3;

  traffic_lamp_monitor u_dut0 (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clr_err(clr_err),
    .phase(ph_o[0]), .phase_valid(pv_o[0]), .cycle_count(cc0), .err_pulse(ep_o[0]),
    .err_sticky(es_o[0]), .err_code(ec_o[0])
  );

  traffic_lamp_monitor #(.GRN_MAX(3)) u_dut1 (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clr_err(clr_err),
    .phase(ph_o[1]), .phase_valid(pv_o[1]), .cycle_count(cc1), .err_pulse(ep_o[1]),
    .err_sticky(es_o[1]), .err_code(ec_o[1])
  );

  traffic_lamp_monitor #(.CYC_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clr_err(clr_err),
    .phase(ph_o[2]), .phase_valid(pv_o[2]), .cycle_count(cc2), .err_pulse(ep_o[2]),
    .err_sticky(es_o[2]), .err_code(ec_o[2])
  );

  traffic_lamp_monitor #(
    .RED_MIN(2), .RED_MAX(5), .GRN_MIN(2), .GRN_MAX(4), .YEL_MIN(1), .YEL_MAX(2)
  ) u_dut3 (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clr_err(clr_err),
    .phase(ph_o[3]), .phase_valid(pv_o[3]), .cycle_count(cc3), .err_pulse(ep_o[3]),
    .err_sticky(es_o[3]), .err_code(ec_o[3])
  );

  // Per-instance limits indexed [dut][phase], and cycle-counter modulus.
  int mn [NDut][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}, '{2, 2, 1}};
  int mx [NDut][3] = '{'{1, 1, 1}, '{1, 3, 1}, '{1, 1, 1}, '{5, 4, 2}};
  int cmod [NDut]  = '{65536, 65536, 4, 65536};

  typedef struct {
    bit [2:0] samp;
    bit       track;
    int       ph;
    int       dwell;
    bit       chk;
    int       cyc;
    bit       pulse;
    bit       sticky;
    int       code;
  } mdl_t;

  mdl_t m [NDut];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int lamp_idx(bit [2:0] s);
    if (s[2]) return 0;
    if (s[0]) return 1;
    return 2;
  endfunction

  function automatic logic [2:0] idx_lamp(int p);
    if (p == 0) return LR;
    if (p == 1) return LG;
    return LY;
  endfunction

  task automatic model_reset(input int i);
    m[i] = '{default: 0};
  endtask

  // One clock edge of the reference: act on the previously sampled lamps,
  // then sample the current pins.
  task automatic model_step(input int i, input bit [2:0] pins, input bit clr);
    mdl_t x;
    int   raise;
    int   p;
    x     = m[i];
    raise = 0;
    if (!x.track) begin
      if ($countones(x.samp) == 1) begin
        x.track = 1'b1;
        x.ph    = lamp_idx(x.samp);
        x.dwell = 1;
        x.chk   = 1'b0;
      end
    end else if ($countones(x.samp) != 1) begin
      raise   = 1;
      x.track = 1'b0;
    end else begin
      p = lamp_idx(x.samp);
      if (p == x.ph) begin
        if (DwellEn && x.dwell == mx[i][x.ph]) raise = 4;
        if (x.dwell < 65535) x.dwell++;
      end else if (p == (x.ph + 1) % 3) begin
        if (DwellEn && x.chk && x.dwell < mn[i][x.ph]) raise = 3;
        if (x.ph == 2) x.cyc = (x.cyc + 1) % cmod[i];
        x.ph    = p;
        x.dwell = 1;
        x.chk   = 1'b1;
      end else begin
        raise   = 2;
        x.ph    = p;
        x.dwell = 1;
        x.chk   = 1'b0;
      end
    end
    x.pulse = raise != 0;
    if (raise != 0) begin
      if (!x.sticky || clr) x.code = raise;
      x.sticky = 1'b1;
    end else if (clr) begin
      x.sticky = 1'b0;
      x.code   = 0;
    end
    x.samp = pins;
    m[i]   = x;
  endtask

  // Drive one cycle of pins, advance the model at the edge, settle #1 after.
  task automatic cycle(input logic [2:0] l, input logic c);
    {red, yellow, green} = l;
    clr_err = c;
    @(posedge clk);
    for (int i = 0; i < NDut; i++) begin
      if (reset) model_reset(i);
      else model_step(i, l, c);
    end
    #1;
  endtask

  task automatic do_reset();
    {red, yellow, green} = LOff;
    clr_err = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NDut; i++) model_reset(i);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NDut; i++) begin
      n_checks++;
      if ({ph_o[i], pv_o[i], cc_o[i], ep_o[i], es_o[i], ec_o[i]} !== 24'd0)
        $display("FAIL reset_outputs dut%0d got ph=%0d pv=%0d cc=%0d ep=%0d es=%0d ec=%0d want all 0",
                 i, ph_o[i], pv_o[i], cc_o[i], ep_o[i], es_o[i], ec_o[i]);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_sequence();
    do_reset();
    cycle(LR, 1'b0);
    n_checks++;
    if (pv_o[0] !== 1'b0) $display("FAIL seq_valid_edge1 got %0d want 0", pv_o[0]);
    else n_pass++;
    cycle(LG, 1'b0);
    n_checks++;
    if (pv_o[0] !== 1'b1 || ph_o[0] !== 2'b00)
      $display("FAIL seq_valid_edge2 got pv=%0d ph=%0d want pv=1 ph=0", pv_o[0], ph_o[0]);
    else n_pass++;
    cycle(LY, 1'b0);
    cycle(LR, 1'b0);
    cycle(LG, 1'b0);
    cycle(LY, 1'b0);
    cycle(LR, 1'b0);
    n_checks++;
    if (es_o[0] !== 1'b0) $display("FAIL seq_no_error got %0d want 0", es_o[0]);
    else n_pass++;
    cycle(LR, 1'b0);
    n_checks++;
    if (cc_o[0] !== 16'd2 || cc_o[2] !== 16'd2 || es_o[0] !== 1'b0)
      $display("FAIL seq_cycle_count got cc0=%0d cc2=%0d es=%0d want 2 2 0",
               cc_o[0], cc_o[2], es_o[0]);
    else n_pass++;
  endtask

  task automatic test_bad_seq();
    do_reset();
    cycle(LR, 1'b0);
    cycle(LY, 1'b0);
    cycle(LR, 1'b0);
    n_checks++;
    if (ep_o[0] !== 1'b1 || ec_o[0] !== 3'd2 || ph_o[0] !== 2'b10 || pv_o[0] !== 1'b1)
      $display("FAIL bad_seq got ep=%0d ec=%0d ph=%0d pv=%0d want 1 2 2 1",
               ep_o[0], ec_o[0], ph_o[0], pv_o[0]);
    else n_pass++;
    cycle(LR, 1'b0);
    n_checks++;
    if (ep_o[0] !== 1'b0 || es_o[0] !== 1'b1 || ec_o[0] !== 3'd2 || ph_o[0] !== 2'b00)
      $display("FAIL bad_seq_after got ep=%0d es=%0d ec=%0d ph=%0d want 0 1 2 0",
               ep_o[0], es_o[0], ec_o[0], ph_o[0]);
    else n_pass++;
  endtask

  task automatic test_not_onehot();
    do_reset();
    cycle(LR, 1'b0);
    cycle(LR | LG, 1'b0);
    cycle(LG, 1'b0);
    n_checks++;
    if (ep_o[0] !== 1'b1 || ec_o[0] !== 3'd1 || pv_o[0] !== 1'b0 || ph_o[0] !== 2'b00)
      $display("FAIL not_onehot got ep=%0d ec=%0d pv=%0d ph=%0d want 1 1 0 0",
               ep_o[0], ec_o[0], pv_o[0], ph_o[0]);
    else n_pass++;
    cycle(LY, 1'b0);
    n_checks++;
    if (ep_o[0] !== 1'b0 || pv_o[0] !== 1'b1 || ph_o[0] !== 2'b01 || ec_o[0] !== 3'd1)
      $display("FAIL resync got ep=%0d pv=%0d ph=%0d ec=%0d want 0 1 1 1",
               ep_o[0], pv_o[0], ph_o[0], ec_o[0]);
    else n_pass++;
  endtask

  task automatic test_long_dwell();
    int pulses;
    do_reset();
    pulses = 0;
    cycle(LR, 1'b0);
    cycle(LG, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle((k < 4) ? LG : LY, 1'b0);
      if (ep_o[1] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== (DwellEn ? 1 : 0))
      $display("FAIL long_dwell_pulses got %0d want %0d", pulses, DwellEn ? 1 : 0);
    else n_pass++;
    n_checks++;
    if (ec_o[1] !== (DwellEn ? 3'd4 : 3'd0))
      $display("FAIL long_dwell_code got %0d want %0d", ec_o[1], DwellEn ? 4 : 0);
    else n_pass++;
  endtask

  task automatic test_sticky_clear();
    do_reset();
    cycle(LR, 1'b0);
    cycle(LY, 1'b0);
    cycle(LOff, 1'b0);
    cycle(LR, 1'b0);
    n_checks++;
    if (ep_o[0] !== 1'b1 || ec_o[0] !== 3'd2 || es_o[0] !== 1'b1)
      $display("FAIL first_code_kept got ep=%0d ec=%0d es=%0d want 1 2 1",
               ep_o[0], ec_o[0], es_o[0]);
    else n_pass++;
    cycle(LY, 1'b0);
    cycle(LOff, 1'b1);
    n_checks++;
    if (ep_o[0] !== 1'b1 || es_o[0] !== 1'b1 || ec_o[0] !== 3'd2)
      $display("FAIL clr_with_bad_seq got ep=%0d es=%0d ec=%0d want 1 1 2",
               ep_o[0], es_o[0], ec_o[0]);
    else n_pass++;
    cycle(LOff, 1'b1);
    n_checks++;
    if (es_o[0] !== 1'b1 || ec_o[0] !== 3'd1)
      $display("FAIL clr_with_not_onehot got es=%0d ec=%0d want 1 1", es_o[0], ec_o[0]);
    else n_pass++;
    cycle(LR, 1'b1);
    n_checks++;
    if (es_o[0] !== 1'b0 || ec_o[0] !== 3'd0 || ep_o[0] !== 1'b0)
      $display("FAIL clr_alone got es=%0d ec=%0d ep=%0d want 0 0 0", es_o[0], ec_o[0], ep_o[0]);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(LR, 1'b0);
      cycle(LG, 1'b0);
      cycle(LY, 1'b0);
    end
    cycle(LR, 1'b0);
    cycle(LR, 1'b0);
    n_checks++;
    if (cc_o[2] !== 16'd1 || cc_o[0] !== 16'd5)
      $display("FAIL cycle_wrap got cc2=%0d cc0=%0d want 1 5", cc_o[2], cc_o[0]);
    else n_pass++;
    cycle(LG, 1'b0);
    cycle(LG, 1'b0);
    n_checks++;
    if (ph_o[0] !== 2'b01 || pv_o[0] !== 1'b1)
      $display("FAIL mid_green got ph=%0d pv=%0d want 1 1", ph_o[0], pv_o[0]);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < NDut; i++) model_reset(i);
    #1;
    for (int i = 0; i < NDut; i++) begin
      n_checks++;
      if ({ph_o[i], pv_o[i], cc_o[i], ep_o[i], es_o[i], ec_o[i]} !== 24'd0)
        $display("FAIL mid_reset dut%0d got ph=%0d pv=%0d cc=%0d ep=%0d es=%0d ec=%0d want all 0",
                 i, ph_o[i], pv_o[i], cc_o[i], ep_o[i], es_o[i], ec_o[i]);
      else n_pass++;
    end
    cycle(LG, 1'b0);
    reset = 1'b0;
    cycle(LG, 1'b0);
    cycle(LG, 1'b0);
    n_checks++;
    if (pv_o[0] !== 1'b1 || ph_o[0] !== 2'b01 || es_o[0] !== 1'b0 || ep_o[0] !== 1'b0)
      $display("FAIL post_reset_resync got pv=%0d ph=%0d es=%0d ep=%0d want 1 1 0 0",
               pv_o[0], ph_o[0], es_o[0], ep_o[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int         cur;
    int         r;
    logic [2:0] l;
    logic       c;
    do_reset();
    cur = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      if (r < 55) begin
        l = idx_lamp(cur);
      end else if (r < 85) begin
        cur = (cur + 1) % 3;
        l   = idx_lamp(cur);
      end else if (r < 93) begin
        cur = $urandom_range(2);
        l   = idx_lamp(cur);
      end else begin
        l = 3'($urandom_range(7));
      end
      c     = ($urandom_range(19) == 0);
      reset = ($urandom_range(99) == 0);
      cycle(l, c);
      for (int i = 0; i < NDut; i++) begin
        n_checks++;
        if (ph_o[i] !== 2'(m[i].ph))
          $display("FAIL rand dut%0d phase got %0d want %0d", i, ph_o[i], m[i].ph);
        else n_pass++;
        n_checks++;
        if (pv_o[i] !== m[i].track)
          $display("FAIL rand dut%0d phase_valid got %0d want %0d", i, pv_o[i], m[i].track);
        else n_pass++;
        n_checks++;
        if (cc_o[i] !== 16'(m[i].cyc))
          $display("FAIL rand dut%0d cycle_count got %0d want %0d", i, cc_o[i], m[i].cyc);
        else n_pass++;
        n_checks++;
        if (ep_o[i] !== m[i].pulse)
          $display("FAIL rand dut%0d err_pulse got %0d want %0d", i, ep_o[i], m[i].pulse);
        else n_pass++;
        n_checks++;
        if (es_o[i] !== m[i].sticky)
          $display("FAIL rand dut%0d err_sticky got %0d want %0d", i, es_o[i], m[i].sticky);
        else n_pass++;
        n_checks++;
        if (ec_o[i] !== 3'(m[i].code))
          $display("FAIL rand dut%0d err_code got %0d want %0d", i, ec_o[i], m[i].code);
        else n_pass++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bad_seq();
    test_not_onehot();
    test_long_dwell();
    test_sticky_clear();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Passive checker on the lamp outputs of the traffic-light controller: samples `red`/`yellow`/`green`, rebuilds the phase, and checks that exactly one lamp is lit and that phases follow RED→GREEN→YELLOW→RED. It can also check each phase's dwell time against min/max limits. It counts completed light cycles and reports errors through a sticky flag, a first-error code and a one-cycle pulse. It sits beside the controller in the top level or in the bench and never drives the lamps.

## Interface
- `DWELL_W`, 16, dwell counter width in cycles, saturating
- `CYC_W`, 16, completed-cycle counter width, wrapping
- `RED_MIN` / `RED_MAX`, 1 / 1, legal RED dwell in cycles (inclusive)
- `GRN_MIN` / `GRN_MAX`, 1 / 1, legal GREEN dwell in cycles (inclusive)
- `YEL_MIN` / `YEL_MAX`, 1 / 1, legal YELLOW dwell in cycles (inclusive)
- `clk` in 1 — clock
- `reset` in 1 — asynchronous, active-high
- `red` / `yellow` / `green` in 1 each — lamp inputs
- `clr_err` in 1 — synchronous clear of `err_sticky` and `err_code`
- `phase` out 2 — tracked phase: RED=00, GREEN=01, YELLOW=10
- `phase_valid` out 1 — monitor is in TRACK
- `cycle_count` out CYC_W — completed YELLOW→RED transitions
- `err_pulse` out 1 — one cycle high per detected error
- `err_sticky` out 1 — set on any error, held until `clr_err`
- `err_code` out 3 — code of the first error since the last clear

## Operation
- Error codes: 0 NONE, 1 NOT_ONEHOT, 2 BAD_SEQ, 3 SHORT_DWELL, 4 LONG_DWELL.
- Input stage: the three lamps are registered into `lamp_q` every cycle.
- SYNC state (entered after reset):
  - Waits for a one-hot `lamp_q`, then enters TRACK with `phase` set to that lamp and `dwell` = 1.
  - A non-one-hot `lamp_q` in SYNC raises no error.
- TRACK state, same lamp as `phase`:
  - `dwell` increments, saturating at all-ones.
  - When `dwell` first exceeds MAX, raise LONG_DWELL, once per phase instance.
- TRACK state, legal next lamp:
  - If the outgoing phase had `dwell` < MIN, raise SHORT_DWELL.
  - `phase` updates and `dwell` resets to 1.
  - On YELLOW→RED, `cycle_count` increments and wraps to 0.
- TRACK state, one-hot but illegal next lamp: raise BAD_SEQ, adopt the new phase, `dwell` = 1, stay in TRACK.
- TRACK state, not one-hot (zero or several lamps): raise NOT_ONEHOT, go to SYNC, `phase_valid` = 0; `phase` holds its last value.
- At most one error per cycle. Priority: NOT_ONEHOT > BAD_SEQ > SHORT_DWELL > LONG_DWELL.
- Raising an error: pulse `err_pulse` and set `err_sticky`. Load `err_code` only if `err_sticky` was 0.
- `clr_err` together with a new error in the same cycle: the new error wins. `err_sticky` = 1 and `err_code` = the new code.

## Timing
- Reset values:
  - State SYNC, `lamp_q` = 0, `dwell` = 0
  - `phase` = 00, `phase_valid` = 0, `cycle_count` = 0
  - `err_pulse` = 0, `err_sticky` = 0, `err_code` = 0
- Latency: a lamp change at the pins at edge N is registered at N and acted on at N+1. Outputs therefore reflect the change two edges after it appears at the pins.
- Reset asserted mid-phase: everything returns to reset values at once. After release, the first one-hot sample resynchronises with no error.
- Dwell checks run only in TRACK. The phase adopted on entry from SYNC, and the phase adopted after BAD_SEQ, are not checked for SHORT_DWELL, because their start time is unknown.
- Parameters require MIN ≥ 1, MAX ≥ MIN, and MAX < 2^DWELL_W − 1.

## Configuration
- `TRAFFIC_LAMP_MON_DWELL_CHECK_EN` defined: dwell counter present; SHORT_DWELL and LONG_DWELL checks active.
- Not defined: dwell counter and MIN/MAX compares removed. Codes 3 and 4 are never produced. One-hot, sequence and cycle counting are unchanged.

## Structure
- Shared package `traffic_pkg`:
  - Phase encodings RED/GREEN/YELLOW, matching the controller's.
  - Error-code enum.
  - `next_phase()` legal-successor function.
- One sub-module, `phase_dwell_counter`: saturating counter with restart, plus MIN/MAX compare outputs. Instantiated only under the macro.

## Test plan
- Reset, then drive R,G,Y,R,G,Y,R one cycle each (macro on, default params): `phase_valid` = 1 from the second edge, `cycle_count` = 2, `err_sticky` = 0.
- In TRACK, drive R then Y: `err_pulse` for one cycle, `err_code` = 2, `phase` = YELLOW, `phase_valid` stays 1.
- In TRACK, drive R+G both high: `err_code` = 1, `phase_valid` = 0; next sample G → resync, no new error.
- With GRN_MAX = 3, hold GREEN 5 cycles: exactly one `err_pulse`, `err_code` = 4. Repeat with the macro undefined: no error.
- After a BAD_SEQ, raise NOT_ONEHOT: `err_code` stays 2, `err_pulse` fires again. Then `clr_err` in the same cycle as a BAD_SEQ: `err_sticky` = 1, `err_code` = 2.
- Set CYC_W = 2 and run 5 full cycles: `cycle_count` = 1 (wraps). Assert `reset` mid-GREEN: all outputs return to 0 and the monitor is in SYNC.
